onchip_memory_dp: RTL and testbench

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2), each with per-byte write enables. It is the next generation of the single-port core memories:
- configurable width, depth and read latency (1 or 2)
- readdatavalid/waitrequest handshake on each port
- optional zero-fill sequencer after reset
It sits between a core's data master (s1) and a second master such as DMA or an inter-core mailbox (s2).

---
 rtl/onchip_memory_pkg.sv | 35 +++
 rtl/onchip_memory_rd_pipe.sv | 39 +++
 rtl/onchip_memory_dp.sv | 175 +++++++++++++++++
 tb/tb_onchip_memory_dp.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_memory_pkg.sv
// Shared types, legal parameter values and the byte-merge helper for the
// dual-port on-chip memory.
package onchip_memory_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Widest data bus the merge helper handles; callers extend/truncate.
  localparam int MERGE_MAX_W  = 512;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  function automatic logic is_legal_read_latency(input int lat);
    return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
  endfunction

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_w,
    input logic [MERGE_MAX_W-1:0]  new_w,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MERGE_MAX_BE; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/onchip_memory_rd_pipe.sv
// Per-port read-return pipeline: carries the read strobe and word for
// READ_LATENCY cycles. Everything freezes while en_i is low, so a stall
// stretches latency cycle for cycle and a presented result is held.
module onchip_memory_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];

  // Shift strobe every enabled cycle; data moves only behind a strobe so the
  // output word keeps its last value between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else if (en_i) begin
      vld_q[0] <= vld_i;
      if (vld_i) data_q[0] <= data_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[READ_LATENCY-1];
  assign data_o = data_q[READ_LATENCY-1];

endmodule

// File: rtl/onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports, byte enables,
// configurable read latency and an optional zero-fill after reset.
module onchip_memory_dp
  import onchip_memory_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 13,
  parameter int DEPTH          = 8192,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    init_done
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  if (!is_legal_read_latency(READ_LATENCY)) begin : g_bad_latency
    $error("onchip_memory_dp: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MERGE_MAX_W) begin : g_bad_width
    $error("onchip_memory_dp: DATA_WIDTH must be a multiple of 8 and fit the merge helper");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("onchip_memory_dp: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  // Widen to the helper's bus, merge, and narrow back.
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_WIDTH-1:0]   be
  );
    return DATA_WIDTH'(byte_merge(MERGE_MAX_W'(old_w), MERGE_MAX_W'(new_w),
                                  MERGE_MAX_BE'(be)));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  init_done_q;
  logic                  en;
  logic                  clr_wr;

  assign en     = clken & ~reset_req;
  assign clr_wr = (state_q == ST_CLEAR) & en;

  // Clear sequencer: zero one word per enabled cycle, then park in READY.
  // init_done is registered so it reads 0 while reset is held in any mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (en) begin
            if (clr_addr_q == CLR_LAST) begin
              state_q     <= ST_READY;
              init_done_q <= 1'b1;
            end else begin
              clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_READY: init_done_q <= 1'b1;
        default:  state_q     <= ST_READY;
      endcase
    end
  end

  assign init_done      = init_done_q;
  assign s1_waitrequest = ~init_done_q | ~en;
  assign s2_waitrequest = ~init_done_q | ~en;

  // Request decode; read together with write counts as a write only.
  logic s1_acc, s1_wr, s1_rd, s1_inr;
  logic s2_acc, s2_wr, s2_rd, s2_inr;
  logic [IDX_W-1:0] s1_idx, s2_idx, clr_idx;

  assign s1_acc  = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
  assign s1_wr   = s1_acc & s1_write;
  assign s1_rd   = s1_acc & s1_read & ~s1_write;
  assign s1_inr  = (int'(s1_address) < DEPTH);
  assign s1_idx  = s1_address[IDX_W-1:0];

  assign s2_acc  = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
  assign s2_wr   = s2_acc & s2_write;
  assign s2_rd   = s2_acc & s2_read & ~s2_write;
  assign s2_inr  = (int'(s2_address) < DEPTH);
  assign s2_idx  = s2_address[IDX_W-1:0];

  assign clr_idx = clr_addr_q[IDX_W-1:0];

  // Current contents seen by each port; reads return these (old data) and
  // out-of-range reads return zero.
  logic [DATA_WIDTH-1:0] s1_old, s2_old, s1_rword, s2_rword;

  assign s1_old   = mem_q[s1_idx];
  assign s2_old   = mem_q[s2_idx];
  assign s1_rword = s1_inr ? s1_old : '0;
  assign s2_rword = s2_inr ? s2_old : '0;

  // Next word per port. When both write one word the s1 bytes are laid over
  // the s2 result, so s1 wins on shared bytes and a single store is issued.
  logic                  same_word;
  logic [DATA_WIDTH-1:0] s1_word_d, s2_word_d;

  assign same_word = s1_wr & s2_wr & s1_inr & s2_inr & (s1_address == s2_address);

  always_comb begin
    s1_word_d = merge_word(s1_old, s1_writedata, s1_byteenable);
    s2_word_d = merge_word(s2_old, s2_writedata, s2_byteenable);
    if (same_word) s2_word_d = merge_word(s2_word_d, s1_writedata, s1_byteenable);
  end

  // Storage: zero-fill during CLEAR, port writes once READY.
  always_ff @(posedge clk) begin
    if (clr_wr) mem_q[clr_idx] <= '0;
    if (s1_wr & s1_inr & ~same_word) mem_q[s1_idx] <= s1_word_d;
    if (s2_wr & s2_inr) mem_q[s2_idx] <= s2_word_d;
  end

  onchip_memory_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe_s1 (
    .clk   (clk),
    .reset (reset),
    .en_i  (en),
    .vld_i (s1_rd),
    .data_i(s1_rword),
    .vld_o (s1_readdatavalid),
    .data_o(s1_readdata)
  );

  onchip_memory_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe_s2 (
    .clk   (clk),
    .reset (reset),
    .en_i  (en),
    .vld_i (s2_rd),
    .data_i(s2_rword),
    .vld_o (s2_readdatavalid),
    .data_o(s2_readdata)
  );

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: two instances (read latency 1 and 2, depth 16)
// share one stimulus stream; a behavioural model predicts every output on
// every cycle and directed literal checks pin the model.
module tb_onchip_memory_dp;

  localparam int AW  = 5;
  localparam int DEP = 16;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        reset_req = 1'b0;
  logic        clken     = 1'b1;
  logic          cs [2];
  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] ad [2];
  logic [3:0]    be [2];
  logic [31:0]   wd [2];

  // [instance][port], instance 0 = latency 1, instance 1 = latency 2
  logic [31:0] rdat [2][2];
  logic        rvld [2][2];
  logic        wreq [2][2];
  logic        idone [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEP),
                     .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(ad[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdat[0][0]),
    .s1_readdatavalid(rvld[0][0]), .s1_waitrequest(wreq[0][0]),
    .s2_address(ad[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdat[0][1]),
    .s2_readdatavalid(rvld[0][1]), .s2_waitrequest(wreq[0][1]),
    .init_done(idone[0]));

  onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEP),
                     .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(ad[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdat[1][0]),
    .s1_readdatavalid(rvld[1][0]), .s1_waitrequest(wreq[1][0]),
    .s2_address(ad[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdat[1][1]),
    .s2_readdatavalid(rvld[1][1]), .s2_waitrequest(wreq[1][1]),
    .init_done(idone[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic v; logic [31:0] d; } rec_t;

  logic [31:0] mmem [DEP];
  bit          m_ready;
  int          m_clr;
  int          m_k;            // number of enabled edges since reset
  rec_t        hist [2][4];    // [port][enabled edge mod 4]: read accepted at that edge
  bit          m_ov [2][2];
  logic [31:0] m_od [2][2];

  // Output of a latency-L port after enabled edge k shows the read accepted
  // at enabled edge k-L+1; the word is kept until the next strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready = 1'b0; m_clr = 0; m_k = 0;
      for (int w = 0; w < DEP; w++) mmem[w] = '0;
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < 4; s++) hist[p][s] = '0;
        for (int d = 0; d < 2; d++) begin m_ov[d][p] = 1'b0; m_od[d][p] = '0; end
      end
    end else if (clken && !reset_req) begin
      m_k++;
      for (int p = 0; p < 2; p++) hist[p][m_k % 4] = '0;
      if (!m_ready) begin
        m_clr++;
        if (m_clr == DEP) m_ready = 1'b1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          int ai;
          ai = int'(ad[p]);
          if (cs[p] && rd[p] && !wr[p]) begin
            hist[p][m_k % 4].v = 1'b1;
            hist[p][m_k % 4].d = (ai < DEP) ? mmem[ai] : 32'h0;
          end
        end
        // s2 first, then s1 on top: s1 owns any byte both ports enable
        for (int q = 1; q >= 0; q--) begin
          int ai;
          ai = int'(ad[q]);
          if (cs[q] && wr[q] && ai < DEP)
            for (int b = 0; b < 4; b++)
              if (be[q][b]) mmem[ai][8*b +: 8] = wd[q][8*b +: 8];
        end
      end
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (m_k - d >= 1) begin
            rec_t r;
            r = hist[p][(m_k - d) % 4];
            m_ov[d][p] = r.v;
            if (r.v) m_od[d][p] = r.d;
          end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic en_now;
    en_now = clken & ~reset_req;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("init_done[L%0d]", d + 1), 32'(idone[d]), 32'(m_ready));
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("waitrequest[L%0d s%0d]", d + 1, p + 1), 32'(wreq[d][p]),
            32'(!m_ready || !en_now));
        chk($sformatf("readdatavalid[L%0d s%0d]", d + 1, p + 1), 32'(rvld[d][p]),
            32'(m_ov[d][p]));
        chk($sformatf("readdata[L%0d s%0d]", d + 1, p + 1), rdat[d][p], m_od[d][p]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
      ad[p] = '0;   be[p] = '0;   wd[p] = '0;
    end
  endtask

  task automatic put(input int p, input bit r, input bit w, input int a,
                     input logic [3:0] b, input logic [31:0] d);
    cs[p] = 1'b1; rd[p] = r; wr[p] = w;
    ad[p] = a[AW-1:0]; be[p] = b; wd[p] = d;
  endtask

  initial begin
    int n;
    idle();
    reset = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("rst_init_done", 32'(idone[0]), 32'h0);
    chk("rst_waitrequest", 32'(wreq[0][0]), 32'h1);
    chk("rst_readdata", rdat[1][1], 32'h0);
    step();

    // Zero-fill: 16 enabled cycles before init_done
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (idone[0]) break;
      n++;
      step();
    end
    chk("clear_cycles", 32'(n), 32'd16);
    step();

    // Every word reads back zero, back-to-back on both ports
    for (int a = 0; a < DEP; a++) begin
      put(0, 1, 0, a, 4'h0, 32'h0);
      put(1, 1, 0, DEP - 1 - a, 4'h0, 32'h0);
      step();
    end
    idle(); step(); step();

    // Full write, byte-0 write, then read of addr 5
    put(0, 0, 1, 5, 4'hF, 32'hDEADBEEF); step();
    put(0, 0, 1, 5, 4'h1, 32'h000000AA); step();
    put(0, 1, 0, 5, 4'h0, 32'h0);        step();
    idle();
    @(negedge clk);
    chk("lat1_valid", 32'(rvld[0][0]), 32'h1);
    chk("lat1_data", rdat[0][0], 32'hDEADBEAA);
    chk("lat2_early_valid", 32'(rvld[1][0]), 32'h0);
    step();
    @(negedge clk);
    chk("lat2_valid", 32'(rvld[1][0]), 32'h1);
    chk("lat2_data", rdat[1][0], 32'hDEADBEAA);
    chk("lat1_single_pulse", 32'(rvld[0][0]), 32'h0);
    step();

    // be=0 write, out-of-range write, and read+write on one port
    put(0, 0, 1, 5, 4'h0, 32'hFFFFFFFF);
    put(1, 1, 1, 9, 4'hF, 32'h12345678); step();
    put(0, 0, 1, 16, 4'hF, 32'hCAFEF00D); step();
    put(0, 1, 0, 5, 4'h0, 32'h0);
    put(1, 1, 0, 9, 4'h0, 32'h0); step();
    put(0, 1, 0, 0, 4'h0, 32'h0);
    put(1, 1, 0, 5, 4'h0, 32'h0); step();
    idle(); step(); step();

    // Same-cycle merge on addr 7 (byte 3 preset to AA first)
    put(1, 0, 1, 7, 4'h8, 32'hAABBCCDD); step();
    put(0, 0, 1, 7, 4'h3, 32'h11223344);
    put(1, 0, 1, 7, 4'h6, 32'hAABBCCDD); step();
    put(0, 1, 0, 7, 4'h0, 32'h0);
    put(1, 1, 0, 7, 4'h0, 32'h0);        step();
    idle();
    @(negedge clk);
    chk("merge_s1", rdat[0][0], 32'hAABB3344);
    chk("merge_s2", rdat[0][1], 32'hAABB3344);
    step(); step();

    // Mixed-port read-during-write on addr 3
    put(0, 0, 1, 3, 4'hF, 32'h00000055);
    put(1, 1, 0, 3, 4'h0, 32'h0); step();
    idle();
    put(1, 1, 0, 3, 4'h0, 32'h0);
    @(negedge clk);
    chk("rdw_old_valid", 32'(rvld[0][1]), 32'h1);
    chk("rdw_old_data", rdat[0][1], 32'h0);
    step();
    idle();
    @(negedge clk);
    chk("rdw_new_l1", rdat[0][1], 32'h55);
    chk("rdw_old_l2", rdat[1][1], 32'h0);
    step();
    @(negedge clk);
    chk("rdw_new_l2", rdat[1][1], 32'h55);
    step(); step();

    // Stall: read at T, reset_req over T+1..T+3 with requests pending
    put(0, 1, 0, 5, 4'h0, 32'h0); step();
    reset_req = 1'b1;
    idle();
    put(0, 1, 0, 7, 4'h0, 32'h0);
    put(1, 1, 0, 7, 4'h0, 32'h0);
    @(negedge clk);
    chk("stall_wait_s1", 32'(wreq[0][0]), 32'h1);
    chk("stall_wait_s2", 32'(wreq[0][1]), 32'h1);
    chk("stall_first_valid", 32'(rvld[0][0]), 32'h1);
    chk("stall_first_data", rdat[0][0], 32'hDEADBEAA);
    step(); step();
    @(negedge clk);
    chk("stall_valid_held", 32'(rvld[0][0]), 32'h1);
    chk("stall_l2_not_yet", 32'(rvld[1][0]), 32'h0);
    step();
    reset_req = 1'b0;
    idle();
    @(negedge clk);
    chk("stall_l2_frozen", 32'(rvld[1][0]), 32'h0);
    step();
    @(negedge clk);
    chk("stall_l1_done", 32'(rvld[0][0]), 32'h0);
    chk("stall_l2_valid", 32'(rvld[1][0]), 32'h1);
    chk("stall_l2_data", rdat[1][0], 32'hDEADBEAA);
    step(); step();

    // Reset at clear word 9, then restart counted in enabled cycles
    reset = 1'b1; step(); step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step();
    @(negedge clk);
    chk("midclear_not_done", 32'(idone[0]), 32'h0);
    step();
    reset = 1'b1; step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (idone[0]) break;
      if (!reset_req) n++;
      step();
      reset_req = (i % 3 == 1);
    end
    chk("restart_en_cycles", 32'(n), 32'd16);
    reset_req = 1'b0;
    step();

    // Contents zeroed again; out-of-range read returns 0 with valid
    put(0, 1, 0, 5, 4'h0, 32'h0);
    put(1, 1, 0, 7, 4'h0, 32'h0);        step();
    put(0, 0, 1, 2, 4'hF, 32'h99990001); step();
    put(0, 1, 0, 2, 4'h0, 32'h0);        step();
    put(0, 1, 0, 20, 4'h0, 32'h0);       step();
    idle();
    @(negedge clk);
    chk("oor_valid", 32'(rvld[0][0]), 32'h1);
    chk("oor_data", rdat[0][0], 32'h0);
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
